// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 32:1 mux scan controller.
package mux_scan_pkg;

    localparam int SEL_W   = 5;
    localparam int N_CH    = 32;
    localparam int LAST_CH = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mux_scan_ctrl_dwell_timer.sv
// Per-channel dwell counter: loads a count, decrements while enabled,
// flags zero on the last dwell cycle.
module scan_dwell_timer #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] val,
    output logic             zero
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans the 32:1 bit-select mux and assembles a 32-bit snapshot word.
// Optional MUX_SCAN_PARITY_EN adds a registered parity output over word.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [DIV_W-1:0] div,
    output logic [SEL_W-1:0] sel,
    input  logic             mux_o,
    output logic             busy,
    output logic             done,
    output logic [N_CH-1:0]  word,
    output logic             word_valid
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic             parity
`endif
);

    state_t          state;
    logic [N_CH-1:0] shadow;
    logic            zero;
    logic            load;
    logic            last;

    assign last = (sel == SEL_W'(LAST_CH));

    // Reload on scan entry, on each channel advance, and on continuous restart.
    always_comb begin
        load = 1'b0;
        unique case (state)
            IDLE:    load = start && !stop;
            SCAN:    load = !stop && zero && !last;
            DONE:    load = mode && !stop;
            default: load = 1'b0;
        endcase
    end

    scan_dwell_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .en   (state == SCAN),
        .val  (div),
        .zero (zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            word       <= '0;
            word_valid <= 1'b0;
            shadow     <= '0;
`ifdef MUX_SCAN_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state  <= SCAN;
                        sel    <= '0;
                        shadow <= '0;
                        busy   <= 1'b1;
                    end
                end
                SCAN: begin
                    if (stop) begin
                        state <= IDLE;
                        sel   <= '0;
                        busy  <= 1'b0;
                    end else if (zero) begin
                        shadow[sel] <= mux_o;
                        if (last) begin
                            state <= DONE;
                        end else begin
                            sel <= sel + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done       <= 1'b1;
                    word       <= shadow;
                    word_valid <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                    parity     <= ^shadow;
`endif
                    sel        <= '0;
                    if (mode && !stop) begin
                        state  <= SCAN;
                        shadow <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    sel   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
